// File: rtl/alu_initiator.sv
// Host-side initiator that sequences one opcode/operand transfer to an ALU and holds its response.
// Optional done-timeout is enabled by defining ALU_INITIATOR_TIMEOUT_EN.
module alu_initiator #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_opcode,
    input  logic [DATA_WIDTH-1:0] cmd_op_a,
    input  logic [DATA_WIDTH-1:0] cmd_op_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_timeout,
    output logic                  reset_n,
    output logic                  opcode_valid,
    output logic                  opcode,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  done,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  overflow,
    output logic                  proto_err
);

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_DONE,
        RESP
    } state_t;

    state_t                state;
    logic                  hold_cnt;
    logic [DATA_WIDTH-1:0] op_b_q;

`ifdef ALU_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Last permitted WAIT_DONE cycle is the one where the count reads TIMEOUT_CYCLES-1.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == SEND_B) begin
            wait_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign rsp_timeout        = 1'b0;
`endif

    // NOTE: every output is a register updated on the transition into the state that owns it,
    // so the host and ALU see glitch-free levels exactly aligned with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RST_HOLD;
            hold_cnt     <= 1'b0;
            op_b_q       <= '0;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            reset_n      <= 1'b0;
            opcode_valid <= 1'b0;
            opcode       <= 1'b0;
            data         <= '0;
            proto_err    <= 1'b0;
`ifdef ALU_INITIATOR_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
`endif
        end else begin
            // The ALU is itself held in reset during RST_HOLD, so done there is not an error.
            if (done && (state inside {IDLE, SEND_A, SEND_B, RESP})) begin
                proto_err <= 1'b1;
            end

            unique case (state)
                RST_HOLD: begin
                    if (hold_cnt) begin
                        state     <= IDLE;
                        reset_n   <= 1'b1;
                        cmd_ready <= 1'b1;
                    end else begin
                        hold_cnt <= 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_valid) begin
                        state        <= SEND_A;
                        cmd_ready    <= 1'b0;
                        opcode_valid <= 1'b1;
                        opcode       <= cmd_opcode;
                        data         <= cmd_op_a;
                        op_b_q       <= cmd_op_b;
                    end
                end
                SEND_A: begin
                    state        <= SEND_B;
                    opcode_valid <= 1'b0;
                    opcode       <= 1'b0;
                    data         <= op_b_q;
                end
                SEND_B: begin
                    state <= WAIT_DONE;
                    data  <= '0;
                end
                WAIT_DONE: begin
                    if (done) begin
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_result   <= result;
                        rsp_overflow <= overflow;
`ifdef ALU_INITIATOR_TIMEOUT_EN
                        rsp_timeout  <= 1'b0;
                    end else if (timeout_hit) begin
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_result   <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_timeout  <= 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= RST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_initiator.sv
// Self-checking bench for alu_initiator: transaction-level reference model plus directed vectors.
// Define ALU_INITIATOR_TIMEOUT_EN to exercise the timeout build.
module tb_alu_initiator;

    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_opcode;
    logic [DW-1:0] cmd_op_a, cmd_op_b;
    logic          rsp_valid, rsp_ready, rsp_overflow, rsp_timeout;
    logic [DW-1:0] rsp_result;
    logic          reset_n, opcode_valid, opcode;
    logic [DW-1:0] data;
    logic          done, overflow, proto_err;
    logic [DW-1:0] result;

    // ALU side: either driven by hand or by an auto responder that adds the two operands.
    logic          man_done, man_overflow;
    logic [DW-1:0] man_result;
    logic          auto_en;
    logic          auto_done = 1'b0, auto_ovf = 1'b0;
    logic [DW-1:0] auto_result = '0, auto_a = '0, auto_b = '0;
    int            auto_ph = 0;

    assign done     = man_done | auto_done;
    assign result   = auto_en ? auto_result : man_result;
    assign overflow = auto_en ? auto_ovf : man_overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_initiator #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
        .reset_n(reset_n), .opcode_valid(opcode_valid), .opcode(opcode), .data(data),
        .done(done), .result(result), .overflow(overflow), .proto_err(proto_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: m_age counts cycles since command acceptance (1 = opcode strobe,
    // 2 = second operand, >=3 = waiting; wait cycle number is m_age-2); -1 means no command.
    int            m_rel = 0;
    int            m_age = -1;
    bit            m_rsp = 1'b0, m_perr = 1'b0, m_op = 1'b0, m_ovf = 1'b0, m_to = 1'b0;
    logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rel  <= 0;
            m_age  <= -1;
            m_rsp  <= 1'b0;
            m_perr <= 1'b0;
            m_op   <= 1'b0;
            m_a    <= '0;
            m_b    <= '0;
            m_res  <= '0;
            m_ovf  <= 1'b0;
            m_to   <= 1'b0;
        end else if (m_rel < 2) begin
            m_rel <= m_rel + 1;
        end else if (m_rsp) begin
            if (done) m_perr <= 1'b1;
            if (rsp_ready) begin
                m_rsp <= 1'b0;
                m_age <= -1;
            end
        end else if (m_age < 3) begin
            if (done) m_perr <= 1'b1;
            if (m_age == -1) begin
                if (cmd_valid) begin
                    m_op  <= cmd_opcode;
                    m_a   <= cmd_op_a;
                    m_b   <= cmd_op_b;
                    m_age <= 1;
                end
            end else begin
                m_age <= m_age + 1;
            end
        end else if (done) begin
            m_rsp <= 1'b1;
            m_res <= result;
            m_ovf <= overflow;
            m_to  <= 1'b0;
`ifdef ALU_INITIATOR_TIMEOUT_EN
        end else if (m_age - 2 >= TO) begin
            m_rsp <= 1'b1;
            m_res <= '0;
            m_ovf <= 1'b0;
            m_to  <= 1'b1;
`endif
        end else begin
            m_age <= m_age + 1;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        check("cmp.reset_n", 32'(reset_n), 32'(m_rel >= 2));
        check("cmp.cmd_ready", 32'(cmd_ready), 32'(m_rel >= 2 && m_age == -1 && !m_rsp));
        check("cmp.opcode_valid", 32'(opcode_valid), 32'(m_age == 1));
        check("cmp.opcode", 32'(opcode), 32'(m_age == 1 ? m_op : 1'b0));
        check("cmp.data", 32'(data), 32'(m_age == 1 ? m_a : (m_age == 2 ? m_b : '0)));
        check("cmp.rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        check("cmp.rsp_result", 32'(rsp_result), 32'(m_res));
        check("cmp.rsp_overflow", 32'(rsp_overflow), 32'(m_ovf));
        check("cmp.rsp_timeout", 32'(rsp_timeout), 32'(m_to));
        check("cmp.proto_err", 32'(proto_err), 32'(m_perr));
    end

    // Auto ALU: captures operands off the bus and answers in the first WAIT_DONE cycle.
    always @(negedge clk) begin
        if (!auto_en || reset) begin
            auto_done <= 1'b0;
            auto_ph   <= 0;
        end else begin
            auto_done <= 1'b0;
            if (opcode_valid) begin
                auto_a  <= data;
                auto_ph <= 1;
            end else if (auto_ph == 1) begin
                auto_b  <= data;
                auto_ph <= 2;
            end else if (auto_ph == 2) begin
                auto_done               <= 1'b1;
                {auto_ovf, auto_result} <= {1'b0, auto_a} + {1'b0, auto_b};
                auto_ph                 <= 0;
            end
        end
    end

    int cyc_cnt = 0;
    int ov_times[$];

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (opcode_valid) ov_times.push_back(cyc_cnt);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b1;
        cmd_opcode   = 1'b0;
        cmd_op_a     = 8'h12;
        cmd_op_b     = 8'h34;
        rsp_ready    = 1'b0;
        man_done     = 1'b0;
        man_result   = '0;
        man_overflow = 1'b0;
        auto_en      = 1'b0;

        // Reset release with cmd_valid held.
        cyc(3);
        check("rst.rsp_result", 32'(rsp_result), 32'h0);
        check("rst.reset_n", 32'(reset_n), 32'h0);
        reset = 1'b0;
        cyc(1);
        check("hold.reset_n", 32'(reset_n), 32'h0);
        check("hold.cmd_ready", 32'(cmd_ready), 32'h0);
        cyc(1);
        check("idle.reset_n", 32'(reset_n), 32'h1);
        check("idle.cmd_ready", 32'(cmd_ready), 32'h1);

        // Basic transaction: 12 + 34 = 46.
        cyc(1);
        cmd_valid = 1'b0;
        check("t1.opcode_valid", 32'(opcode_valid), 32'h1);
        check("t1.data_a", 32'(data), 32'h12);
        cyc(1);
        check("t1.strobe_off", 32'(opcode_valid), 32'h0);
        check("t1.data_b", 32'(data), 32'h34);
        cyc(1);
        check("t1.data_wait", 32'(data), 32'h0);
        man_done   = 1'b1;
        man_result = 8'h46;
        cyc(1);
        man_done = 1'b0;
        check("t1.rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1.rsp_result", 32'(rsp_result), 32'h46);
        check("t1.rsp_overflow", 32'(rsp_overflow), 32'h0);
        check("t1.proto_err", 32'(proto_err), 32'h0);

        // Response back-pressure with a new command offered.
        cmd_valid  = 1'b1;
        cmd_opcode = 1'b1;
        cmd_op_a   = 8'hF0;
        cmd_op_b   = 8'h20;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("bp.rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp.rsp_result", 32'(rsp_result), 32'h46);
            check("bp.cmd_ready", 32'(cmd_ready), 32'h0);
            check("bp.opcode_valid", 32'(opcode_valid), 32'h0);
        end
        rsp_ready = 1'b1;
        cyc(1);
        rsp_ready = 1'b0;
        check("bp.release_ready", 32'(cmd_ready), 32'h1);
        check("bp.release_valid", 32'(rsp_valid), 32'h0);

        // Second transaction with a stray done during SEND_A.
        cyc(1);
        cmd_valid = 1'b0;
        check("t2.opcode", 32'(opcode), 32'h1);
        check("t2.data_a", 32'(data), 32'hF0);
        man_done     = 1'b1;
        man_result   = 8'hAA;
        man_overflow = 1'b1;
        cyc(1);
        man_done = 1'b0;
        check("t2.proto_err", 32'(proto_err), 32'h1);
        check("t2.data_b", 32'(data), 32'h20);
        check("t2.no_rsp", 32'(rsp_valid), 32'h0);
        cyc(1);
        man_done     = 1'b1;
        man_result   = 8'h10;
        man_overflow = 1'b1;
        cyc(1);
        man_done     = 1'b0;
        man_overflow = 1'b0;
        check("t2.rsp_result", 32'(rsp_result), 32'h10);
        check("t2.rsp_overflow", 32'(rsp_overflow), 32'h1);
        check("t2.proto_err_sticky", 32'(proto_err), 32'h1);
        rsp_ready = 1'b1;
        cyc(1);

        // Back-to-back commands at minimum spacing: C8 + 64 = 12C.
        auto_en  = 1'b1;
        cmd_valid = 1'b1;
        cmd_opcode = 1'b0;
        cmd_op_a = 8'hC8;
        cmd_op_b = 8'h64;
        ov_times.delete();
        cyc(16);
        cmd_valid = 1'b0;
        cyc(8);
        check("sp.count", 32'(ov_times.size()), 32'd4);
        for (int i = 1; i < ov_times.size(); i++) begin
            check("sp.spacing", 32'(ov_times[i] - ov_times[i-1]), 32'd5);
        end
        check("sp.rsp_result", 32'(rsp_result), 32'h2C);
        check("sp.rsp_overflow", 32'(rsp_overflow), 32'h1);
        auto_en   = 1'b0;
        rsp_ready = 1'b0;

        // Reset asserted while waiting for done.
        cmd_valid = 1'b1;
        cmd_op_a  = 8'h55;
        cmd_op_b  = 8'h66;
        cyc(1);
        cmd_valid = 1'b0;
        cyc(2);
        #2 reset = 1'b1;
        #1;
        check("ar.reset_n", 32'(reset_n), 32'h0);
        check("ar.cmd_ready", 32'(cmd_ready), 32'h0);
        check("ar.rsp_result", 32'(rsp_result), 32'h0);
        check("ar.rsp_overflow", 32'(rsp_overflow), 32'h0);
        check("ar.proto_err", 32'(proto_err), 32'h0);
        check("ar.data", 32'(data), 32'h0);
        cyc(1);
        reset = 1'b0;
        cyc(8);
        check("ar.no_rsp", 32'(rsp_valid), 32'h0);
        check("ar.ready_again", 32'(cmd_ready), 32'h1);

`ifdef ALU_INITIATOR_TIMEOUT_EN
        // done never arrives: response after TO wait cycles.
        cmd_valid = 1'b1;
        cmd_op_a  = 8'h01;
        cmd_op_b  = 8'h02;
        cyc(1);
        cmd_valid = 1'b0;
        cyc(2);
        cyc(TO - 1);
        check("to.before", 32'(rsp_valid), 32'h0);
        cyc(1);
        check("to.rsp_valid", 32'(rsp_valid), 32'h1);
        check("to.rsp_timeout", 32'(rsp_timeout), 32'h1);
        check("to.rsp_result", 32'(rsp_result), 32'h0);
        rsp_ready = 1'b1;
        cyc(1);
        rsp_ready = 1'b0;

        // done on the same edge as the timeout: done wins.
        cmd_valid = 1'b1;
        cyc(1);
        cmd_valid = 1'b0;
        cyc(2);
        cyc(TO - 1);
        man_done   = 1'b1;
        man_result = 8'h77;
        cyc(1);
        man_done = 1'b0;
        check("tie.rsp_timeout", 32'(rsp_timeout), 32'h0);
        check("tie.rsp_result", 32'(rsp_result), 32'h77);
        rsp_ready = 1'b1;
        cyc(1);
        rsp_ready = 1'b0;
`else
        // Without the timeout, WAIT_DONE waits indefinitely.
        cmd_valid = 1'b1;
        cmd_op_a  = 8'h01;
        cmd_op_b  = 8'h02;
        cyc(1);
        cmd_valid = 1'b0;
        cyc(2);
        cyc(40);
        check("nt.still_waiting", 32'(rsp_valid), 32'h0);
        man_done   = 1'b1;
        man_result = 8'h99;
        cyc(1);
        man_done = 1'b0;
        check("nt.rsp_result", 32'(rsp_result), 32'h99);
        check("nt.rsp_timeout", 32'(rsp_timeout), 32'h0);
        rsp_ready = 1'b1;
        cyc(1);
        rsp_ready = 1'b0;
`endif

        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_initiator.md
ALU_INITIATOR -- requirements
Module: alu_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of operands, data bus and result.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum wait for done, in cycles; only used with ALU_INITIATOR_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_opcode  input  1  opcode forwarded to the ALU.
REQ-008 cmd_op_a / cmd_op_b  input  DATA_WIDTH each  first / second operand.
REQ-009 rsp_valid  output  1  response held for host.
REQ-010 rsp_ready  input  1  host accepts response.
REQ-011 rsp_result  output  DATA_WIDTH  captured ALU result.
REQ-012 rsp_overflow  output  1  captured ALU overflow.
REQ-013 rsp_timeout  output  1  response ended by timeout, not done.
REQ-014 reset_n  output  1  active-low reset to the ALU.
REQ-015 opcode_valid  output  1  opcode/first-operand strobe to the ALU.
REQ-016 opcode  output  1  opcode to the ALU.
REQ-017 data  output  DATA_WIDTH  operand bus to the ALU.
REQ-018 done  input  1  ALU completion.
REQ-019 result  input  DATA_WIDTH  ALU result, valid with done.
REQ-020 overflow  input  1  ALU overflow, valid with done.
REQ-021 proto_err  output  1  sticky: done seen outside WAIT_DONE.

Function
REQ-022 States: RST_HOLD, IDLE, SEND_A, SEND_B, WAIT_DONE, RESP.
REQ-023 RST_HOLD: reset_n=0; leaves to IDLE after 2 clk cycles following reset deassertion; reset_n=1 in all other states.
REQ-024 IDLE: cmd_ready=1; cmd_valid&cmd_ready at edge T latches opcode/op_a/op_b, goes SEND_A.
REQ-025 SEND_A (cycle T+1): opcode_valid=1, opcode=latched, data=op_a; next SEND_B.
REQ-026 SEND_B (cycle T+2): opcode_valid=0, data=op_b; next WAIT_DONE.
REQ-027 WAIT_DONE: data=0, opcode_valid=0; done=1 at an edge captures result/overflow, rsp_timeout=0, goes RESP.
REQ-028 RESP: rsp_valid=1, response fields stable; rsp_ready=1 at edge returns to IDLE.
REQ-029 cmd_ready=0 in every state except IDLE; no command overlap.
REQ-030 Minimum command-to-command spacing: 5 cycles (done in first WAIT_DONE cycle, rsp_ready held high).
REQ-031 done in IDLE, SEND_A, SEND_B or RESP: ignored for data; sets proto_err; state unaffected.
REQ-032 data, opcode driven 0 whenever opcode_valid and SEND_B are not active.

Reset
REQ-033 reset asserted: state=RST_HOLD immediately, including mid-transaction; in-flight command discarded, no response.
REQ-034 Reset values: cmd_ready=0, rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_timeout=0, reset_n=0, opcode_valid=0, opcode=0, data=0, proto_err=0, timeout counter=0.

Configuration
REQ-035 Macro ALU_INITIATOR_TIMEOUT_EN defined: counter clears on WAIT_DONE entry, increments each WAIT_DONE cycle; reaching TIMEOUT_CYCLES without done goes RESP with rsp_timeout=1, rsp_result=0, rsp_overflow=0.
REQ-036 done and timeout on same edge: done wins, rsp_timeout=0.
REQ-037 Macro undefined: no counter; WAIT_DONE waits indefinitely; rsp_timeout tied 0.

Verification
REQ-038 Reset release, cmd_valid held: reset_n low 2 cycles post-release, cmd_ready first high in cycle 3.
REQ-039 Command opcode=0, A=8'h12, B=8'h34, ALU done 1 cycle into WAIT_DONE with result=8'h46, overflow=0 -> opcode_valid one cycle with data=8'h12, then data=8'h34; rsp_valid with rsp_result=8'h46, rsp_overflow=0.
REQ-040 rsp_ready held low 10 cycles in RESP -> rsp_valid and fields stable, cmd_ready=0, new cmd_valid not accepted.
REQ-041 done pulsed during SEND_A -> proto_err=1 sticky, transaction still completes normally.
REQ-042 With ALU_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never asserted -> rsp_valid after 16 WAIT_DONE cycles with rsp_timeout=1, rsp_result=0.
REQ-043 reset asserted in WAIT_DONE -> all outputs to reset values asynchronously; no rsp_valid for that command.
